// File: rtl/popacc_pkg.sv
// popacc_pkg: shared FSM states, clamp ceiling and sum-width helper for the popcount window accumulator.
package popacc_pkg;
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam logic [3:0] POP_MAX = 4'd8;
  function automatic int acc_width(input int window);
    return $clog2(window * 8 + 1);
  endfunction
endpackage

// File: rtl/popcount_window_acc_if.sv
// popcount_window_acc_if: sample-in and result-out valid/ready bundle.
interface popcount_window_acc_if #(parameter int ACC_W = 7);
  logic in_valid;
  logic [3:0] in_count;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [3:0] out_max;
  logic out_err;
  modport master (
    output in_valid, in_count, out_ready,
    input in_ready, out_valid, out_sum, out_max, out_err
  );
  modport slave (
    input in_valid, in_count, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_err
  );
endinterface

// File: rtl/popacc_clamp.sv
// popacc_clamp: clamps a 4-bit popcount to POP_MAX and flags over-range input.
module popacc_clamp
  import popacc_pkg::*;
(
  input logic [3:0] s,
  output logic [3:0] c,
  output logic over
);
  assign over = s > POP_MAX;
  assign c = over ? POP_MAX : s;
endmodule

// File: rtl/popcount_window_acc.sv
// popcount_window_acc: sums WINDOW clamped popcount samples and holds the result on a valid/ready port.
// Define POPACC_MAX_EN to build the running maximum; otherwise out_max reads 4'h0.
module popcount_window_acc
  import popacc_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int ACC_W = acc_width(WINDOW)
) (
  input logic clk,
  input logic rst_n,
  input logic clear,
  popcount_window_acc_if.slave bus
);
  localparam int IDX_W = $clog2(WINDOW);
  state_t state, state_n;
  logic ready_q;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc, acc_n, sum_q;
  logic err, err_q, over, take, last;
  logic [3:0] c;
  popacc_clamp u_clamp (.s(bus.in_count), .c(c), .over(over));
  assign take = bus.in_valid && ready_q;
  assign last = take && idx == IDX_W'(WINDOW - 1);
  assign acc_n = acc + ACC_W'(c);
  always_comb begin
    state_n = state;
    state_n = clear ? ACCUM : (state == ACCUM) ? (last ? HOLD : ACCUM) : (bus.out_ready ? ACCUM : HOLD);
  end
  // ready is registered from the next state so it stays low through reset and has no path from out_ready
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ACCUM;
      ready_q <= 1'b0;
      idx <= '0;
      acc <= '0;
      err <= 1'b0;
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      ready_q <= state_n == ACCUM;
      if (clear || last) begin
        idx <= '0;
        acc <= '0;
        err <= 1'b0;
      end else if (take) begin
        idx <= idx + IDX_W'(1);
        acc <= acc_n;
        err <= err | over;
      end
      if (clear) begin
        sum_q <= '0;
        err_q <= 1'b0;
      end else if (last) begin
        sum_q <= acc_n;
        err_q <= err | over;
      end
    end
`ifdef POPACC_MAX_EN
  logic [3:0] maxr, max_q, max_n;
  assign max_n = c > maxr ? c : maxr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      maxr <= '0;
      max_q <= '0;
    end else begin
      if (clear || last) maxr <= '0;
      else if (take) maxr <= max_n;
      if (clear) max_q <= '0;
      else if (last) max_q <= max_n;
    end
  assign bus.out_max = max_q;
`else
  assign bus.out_max = 4'h0;
`endif
  assign bus.in_ready = ready_q;
  assign bus.out_valid = state == HOLD;
  assign bus.out_sum = sum_q;
  assign bus.out_err = err_q;
endmodule

// File: tb/tb_popcount_window_acc.sv
// tb_popcount_window_acc: directed and randomized checks of the window accumulator against a queue-based model.
module tb_popcount_window_acc;
  import popacc_pkg::*;
  localparam int A4 = acc_width(4);
  localparam int A8 = acc_width(8);
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  int passed = 0;
  int total = 0;
  popcount_window_acc_if #(.ACC_W(A4)) b4 ();
  popcount_window_acc_if #(.ACC_W(A8)) b8 ();
  popcount_window_acc #(.WINDOW(4), .ACC_W(A4)) dut4 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(b4));
  popcount_window_acc #(.WINDOW(8), .ACC_W(A8)) dut8 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(b8));
  always #5 clk = ~clk;

  function automatic int cl(input int s);
    return s > 8 ? 8 : s;
  endfunction
  function automatic int em(input int m);
`ifdef POPACC_MAX_EN
    return m;
`else
    return 0 * m;
`endif
  endfunction
  function automatic int ref_sum(input int q[$]);
    int t = 0;
    foreach (q[i]) t += cl(q[i]);
    return t;
  endfunction
  function automatic int ref_max(input int q[$]);
    int m = 0;
    foreach (q[i]) if (cl(q[i]) > m) m = cl(q[i]);
    return em(m);
  endfunction
  function automatic int ref_err(input int q[$]);
    int e = 0;
    foreach (q[i]) if (q[i] > 8) e = 1;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push4(input int s);
    int n = 0;
    b4.in_valid = 1'b1;
    b4.in_count = 4'(s);
    while (!b4.in_ready && n < 50) begin
      step();
      n++;
    end
    if (!b4.in_ready) begin
      $display("FAIL push_timeout in_ready got 0 want 1");
      $fatal(1);
    end
    step();
    b4.in_valid = 1'b0;
  endtask
  task automatic get4(input int delay, output int sum, output int mx, output int err, output int got);
    int n = 0;
    while (!b4.out_valid && n < 100) begin
      step();
      n++;
    end
    got = int'(b4.out_valid);
    repeat (delay) step();
    sum = int'(b4.out_sum);
    mx = int'(b4.out_max);
    err = int'(b4.out_err);
    b4.out_ready = 1'b1;
    step();
    b4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total++; if (b4.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", b4.in_ready); else passed++;
    total++; if (b4.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", b4.out_valid); else passed++;
    total++; if (b4.out_sum !== '0) $display("FAIL reset_out_sum got %0d want 0", b4.out_sum); else passed++;
    total++; if (b4.out_max !== 4'd0 || b4.out_err !== 1'b0) $display("FAIL reset_max_err got %0d/%b want 0/0", b4.out_max, b4.out_err); else passed++;
    step();
    step();
    #3 rst_n = 1'b1;
    #1;
    total++; if (b4.in_ready !== 1'b0) $display("FAIL reset_ready_before_edge got %b want 0", b4.in_ready); else passed++;
    step();
    total++; if (b4.in_ready !== 1'b1 || b8.in_ready !== 1'b1) $display("FAIL reset_ready_after_edge got %b/%b want 1/1", b4.in_ready, b8.in_ready); else passed++;
  endtask

  task automatic test_basic();
    b4.out_ready = 1'b1;
    push4(1);
    push4(2);
    push4(3);
    total++; if (b4.out_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", b4.out_valid); else passed++;
    push4(4);
    total++; if (b4.out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", b4.out_valid); else passed++;
    total++; if (b4.out_sum !== 6'd10) $display("FAIL basic_sum got %0d want 10", b4.out_sum); else passed++;
    total++; if (int'(b4.out_max) !== em(4)) $display("FAIL basic_max got %0d want %0d", b4.out_max, em(4)); else passed++;
    total++; if (b4.out_err !== 1'b0) $display("FAIL basic_err got %b want 0", b4.out_err); else passed++;
    total++; if (b4.in_ready !== 1'b0) $display("FAIL basic_bubble got %b want 0", b4.in_ready); else passed++;
    step();
    b4.out_ready = 1'b0;
    total++; if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) $display("FAIL basic_handoff valid/ready got %b/%b want 0/1", b4.out_valid, b4.in_ready); else passed++;
  endtask

  task automatic test_full_scale();
    b8.in_valid = 1'b1;
    b8.in_count = 4'd8;
    repeat (8) step();
    b8.in_valid = 1'b0;
    total++; if (b8.out_valid !== 1'b1) $display("FAIL full_valid got %b want 1", b8.out_valid); else passed++;
    total++; if (b8.out_sum !== 7'h40) $display("FAIL full_sum got %0d want 64", b8.out_sum); else passed++;
    total++; if (int'(b8.out_max) !== em(8) || b8.out_err !== 1'b0) $display("FAIL full_max_err got %0d/%b want %0d/0", b8.out_max, b8.out_err, em(8)); else passed++;
    b8.out_ready = 1'b1;
    step();
    b8.out_ready = 1'b0;
  endtask

  task automatic test_clamp();
    int s, m, e, g;
    push4(3); push4(15); push4(0); push4(2);
    get4(1, s, m, e, g);
    total++; if (g !== 1) $display("FAIL clamp_timeout got %0d want 1", g); else passed++;
    total++; if (s !== 13 || m !== em(8) || e !== 1) $display("FAIL clamp_win1 got %0d/%0d/%0d want 13/%0d/1", s, m, e, em(8)); else passed++;
    push4(1); push4(1); push4(1); push4(1);
    get4(0, s, m, e, g);
    total++; if (s !== 4 || m !== em(1) || e !== 0) $display("FAIL clamp_win2 got %0d/%0d/%0d want 4/%0d/0", s, m, e, em(1)); else passed++;
  endtask

  task automatic test_backpressure();
    int s, m, e, g;
    b4.out_ready = 1'b0;
    push4(2); push4(4); push4(6); push4(9);
    b4.in_valid = 1'b1;
    b4.in_count = 4'd7;
    for (int i = 0; i < 5; i++) begin
      total++; if (b4.out_valid !== 1'b1 || b4.out_sum !== 6'd20 || b4.in_ready !== 1'b0) $display("FAIL bp_hold%0d got valid=%b sum=%0d ready=%b want 1/20/0", i, b4.out_valid, b4.out_sum, b4.in_ready); else passed++;
      step();
    end
    b4.out_ready = 1'b1;
    step();
    b4.out_ready = 1'b0;
    push4(7); push4(1); push4(0); push4(12);
    get4(2, s, m, e, g);
    total++; if (s !== 16 || m !== em(8) || e !== 1) $display("FAIL bp_next got %0d/%0d/%0d want 16/%0d/1", s, m, e, em(8)); else passed++;
  endtask

  task automatic test_clear_partial();
    int s, m, e, g;
    push4(5); push4(5);
    clear = 1'b1;
    b4.in_valid = 1'b1;
    b4.in_count = 4'd15;
    step();
    clear = 1'b0;
    b4.in_valid = 1'b0;
    total++; if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) $display("FAIL clr_part_state got %b/%b want 0/1", b4.out_valid, b4.in_ready); else passed++;
    push4(1); push4(1); push4(1); push4(1);
    get4(0, s, m, e, g);
    total++; if (s !== 4 || m !== em(1) || e !== 0) $display("FAIL clr_part_sum got %0d/%0d/%0d want 4/%0d/0", s, m, e, em(1)); else passed++;
  endtask

  task automatic test_clear_hold();
    push4(1); push4(2); push4(3); push4(4);
    total++; if (b4.out_valid !== 1'b1) $display("FAIL clr_hold_pre got %b want 1", b4.out_valid); else passed++;
    clear = 1'b1;
    b4.out_ready = 1'b1;
    step();
    clear = 1'b0;
    b4.out_ready = 1'b0;
    total++; if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) $display("FAIL clr_hold_state got %b/%b want 0/1", b4.out_valid, b4.in_ready); else passed++;
    total++; if (b4.out_sum !== '0 || b4.out_max !== 4'd0 || b4.out_err !== 1'b0) $display("FAIL clr_hold_zero got %0d/%0d/%b want 0/0/0", b4.out_sum, b4.out_max, b4.out_err); else passed++;
  endtask

  task automatic test_reset_mid();
    int s, m, e, g;
    push4(1); push4(2); push4(3); push4(4);
    get4(0, s, m, e, g);
    total++; if (s !== 10) $display("FAIL rst_mid_pre got %0d want 10", s); else passed++;
    push4(8); push4(8);
    #3 rst_n = 1'b0;
    #1;
    total++; if (b4.out_sum !== '0 || b4.out_valid !== 1'b0 || b4.in_ready !== 1'b0) $display("FAIL rst_mid_async got %0d/%b/%b want 0/0/0", b4.out_sum, b4.out_valid, b4.in_ready); else passed++;
    #2 rst_n = 1'b1;
    step();
    push4(2); push4(0); push4(7); push4(9);
    get4(1, s, m, e, g);
    total++; if (s !== 17 || m !== em(8) || e !== 1) $display("FAIL rst_mid_win got %0d/%0d/%0d want 17/%0d/1", s, m, e, em(8)); else passed++;
  endtask

  task automatic test_random();
    int q[$];
    int s, m, e, g;
    for (int w = 0; w < 20; w++) begin
      q.delete();
      for (int k = 0; k < 4; k++) q.push_back(int'($urandom_range(0, 15)));
      foreach (q[i]) begin
        repeat ($urandom_range(0, 2)) step();
        push4(q[i]);
      end
      get4(int'($urandom_range(0, 3)), s, m, e, g);
      total++; if (g !== 1) $display("FAIL rnd%0d_timeout got %0d want 1", w, g); else passed++;
      total++; if (s !== ref_sum(q)) $display("FAIL rnd%0d_sum got %0d want %0d", w, s, ref_sum(q)); else passed++;
      total++; if (m !== ref_max(q) || e !== ref_err(q)) $display("FAIL rnd%0d_max_err got %0d/%0d want %0d/%0d", w, m, e, ref_max(q), ref_err(q)); else passed++;
    end
  endtask

  initial begin
    b4.in_valid = 1'b0; b4.in_count = 4'd0; b4.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.in_count = 4'd0; b8.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_full_scale();
    test_clamp();
    test_backpressure();
    test_clear_partial();
    test_clear_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
